// File: rtl/multi_linked_list_pkg.sv
// Shared definitions for the multi-list linked-list manager: op codes, FSM
// states and width helpers used to size ports from the pool and list counts.
package multi_linked_list_pkg;

    typedef enum logic [2:0] {
        OP_READ         = 3'd0,
        OP_INSERT_HEAD  = 3'd1,
        OP_INSERT_TAIL  = 3'd2,
        OP_INSERT_AFTER = 3'd3,
        OP_POP_HEAD     = 3'd4,
        OP_DELETE_ADDR  = 3'd5,
        OP_DELETE_VALUE = 3'd6,
        OP_RESERVED     = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_TRAVERSE,
        ST_DONE
    } state_e;

    // One extra code beyond the pool keeps the all-ones value free for ADDR_NULL.
    function automatic int addr_width_f(input int max_node);
        return $clog2(max_node + 1);
    endfunction

    function automatic int list_width_f(input int num_lists);
        return (num_lists > 1) ? $clog2(num_lists) : 1;
    endfunction

    function automatic int idx_width_f(input int max_node);
        return (max_node > 1) ? $clog2(max_node) : 1;
    endfunction

    function automatic logic [31:0] addr_null_f(input int addr_width);
        return (32'd1 << addr_width) - 32'd1;
    endfunction

endpackage

// File: rtl/ll_free_alloc.sv
// Lowest-index free-node finder and free-node counter over the valid bitmap.
module ll_free_alloc #(
    parameter int MAX_NODE   = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [MAX_NODE-1:0]   valid,
    output logic [ADDR_WIDTH-1:0] free_addr,
    output logic [ADDR_WIDTH-1:0] free_count
);

    logic found;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        free_addr  = '1;
        free_count = '0;
        found      = 1'b0;
        for (int i = 0; i < MAX_NODE; i++) begin
            if (!valid[i]) begin
                free_count = free_count + ADDR_WIDTH'(1);
                if (!found) begin
                    free_addr = ADDR_WIDTH'(i);
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_linked_list.sv
// NUM_LISTS singly linked lists sharing one node pool; one operation at a time
// through op_start/op_done, with delete ops walking the list one node per cycle.
module multi_linked_list
    import multi_linked_list_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_NODE   = 8,
    parameter  int NUM_LISTS  = 4,
    localparam int ADDR_WIDTH = addr_width_f(MAX_NODE),
    localparam int LIST_WIDTH = list_width_f(NUM_LISTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [2:0]                      op,
    input  logic                            op_start,
    input  logic [LIST_WIDTH-1:0]           list_in,
    input  logic [ADDR_WIDTH-1:0]           addr_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [ADDR_WIDTH-1:0]           addr_out,
    output logic [ADDR_WIDTH-1:0]           next_node_addr,
    output logic                            op_done,
    output logic                            fault,
    output logic                            busy,
    output logic [NUM_LISTS*ADDR_WIDTH-1:0] head,
    output logic [NUM_LISTS*ADDR_WIDTH-1:0] tail,
    output logic [NUM_LISTS-1:0]            list_empty,
    output logic [ADDR_WIDTH-1:0]           free_count,
    output logic                            full,
    output logic                            empty
);

    localparam int                    IDX_WIDTH  = idx_width_f(MAX_NODE);
    localparam logic [ADDR_WIDTH-1:0] ADDR_NULL  = ADDR_WIDTH'(addr_null_f(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] MAX_NODE_A = ADDR_WIDTH'(MAX_NODE);

    function automatic logic [IDX_WIDTH-1:0] ix(input logic [ADDR_WIDTH-1:0] a);
        return IDX_WIDTH'(a);
    endfunction

    state_e                  state_q, state_d;
    op_e                     op_q;
    logic [LIST_WIDTH-1:0]   list_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [ADDR_WIDTH-1:0]   cur_q, prev_q;

    logic [MAX_NODE-1:0]     valid_q;
    logic [DATA_WIDTH-1:0]   data_mem [MAX_NODE];
    logic [ADDR_WIDTH-1:0]   next_mem [MAX_NODE];
    logic [ADDR_WIDTH-1:0]   head_q   [NUM_LISTS];
    logic [ADDR_WIDTH-1:0]   tail_q   [NUM_LISTS];

    logic [ADDR_WIDTH-1:0]   free_addr;
    logic                    list_ok, addr_ok, cur_ok, cur_match;
    logic                    exec_fault, trav_end, trav_hit;
    logic [LIST_WIDTH-1:0]   lsel;
    logic [ADDR_WIDTH-1:0]   lhead, ltail, cur_next;

    logic                    dwe, nwe0, nwe1;
    logic [ADDR_WIDTH-1:0]   dwa, nwa0, nwa1, nwd0, nwd1;
    logic [DATA_WIDTH-1:0]   dwd;

    ll_free_alloc #(
        .MAX_NODE   (MAX_NODE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_free_alloc (
        .valid      (valid_q),
        .free_addr  (free_addr),
        .free_count (free_count)
    );

    assign full    = (free_count == '0);
    assign empty   = (free_count == MAX_NODE_A);
    assign op_done = (state_q == ST_DONE);
    assign busy    = (state_q != ST_IDLE);

    for (genvar g = 0; g < NUM_LISTS; g++) begin : g_list
        assign head[g*ADDR_WIDTH +: ADDR_WIDTH] = head_q[g];
        assign tail[g*ADDR_WIDTH +: ADDR_WIDTH] = tail_q[g];
        assign list_empty[g]                    = (head_q[g] == ADDR_NULL);
    end

    assign list_ok   = (32'(list_q) < NUM_LISTS);
    assign lsel      = list_ok ? list_q : '0;
    assign lhead     = head_q[lsel];
    assign ltail     = tail_q[lsel];
    assign addr_ok   = (addr_q < MAX_NODE_A) && valid_q[ix(addr_q)];
    assign cur_ok    = (cur_q < MAX_NODE_A);
    assign cur_next  = next_mem[ix(cur_q)];
    assign cur_match = (op_q == OP_DELETE_ADDR) ? (cur_q == addr_q)
                                                : (data_mem[ix(cur_q)] == data_q);
    assign trav_end  = !list_ok || !cur_ok;
    assign trav_hit  = !trav_end && cur_match;

    always_comb begin
        exec_fault = 1'b1;
        case (op_q)
            OP_READ:         exec_fault = !addr_ok;
            OP_INSERT_HEAD,
            OP_INSERT_TAIL:  exec_fault = !list_ok || full;
            OP_INSERT_AFTER: exec_fault = !list_ok || full || !addr_ok;
            OP_POP_HEAD:     exec_fault = !list_ok || (lhead == ADDR_NULL);
            default:         exec_fault = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    if (op_e'(op) == OP_DELETE_ADDR || op_e'(op) == OP_DELETE_VALUE)
                        state_d = ST_TRAVERSE;
                    else
                        state_d = ST_EXEC;
                end
            end
            ST_EXEC:     state_d = ST_DONE;
            ST_TRAVERSE: if (trav_end || trav_hit) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Node-memory write ports: one data write plus two next-pointer writes
    // (new/unlinked node and its predecessor), never to the same address.
    always_comb begin
        dwe  = 1'b0;  dwa  = '0;  dwd  = '0;
        nwe0 = 1'b0;  nwa0 = '0;  nwd0 = '0;
        nwe1 = 1'b0;  nwa1 = '0;  nwd1 = '0;
        if (state_q == ST_EXEC && !exec_fault) begin
            dwa  = free_addr;
            dwd  = data_q;
            nwa0 = free_addr;
            case (op_q)
                OP_INSERT_HEAD: begin
                    dwe  = 1'b1;
                    nwe0 = 1'b1;
                    nwd0 = lhead;
                end
                OP_INSERT_TAIL: begin
                    dwe  = 1'b1;
                    nwe0 = 1'b1;
                    nwd0 = ADDR_NULL;
                    nwe1 = (ltail != ADDR_NULL);
                    nwa1 = ltail;
                    nwd1 = free_addr;
                end
                OP_INSERT_AFTER: begin
                    dwe  = 1'b1;
                    nwe0 = 1'b1;
                    nwd0 = next_mem[ix(addr_q)];
                    nwe1 = 1'b1;
                    nwa1 = addr_q;
                    nwd1 = free_addr;
                end
                default: ;
            endcase
        end else if (state_q == ST_TRAVERSE && trav_hit && prev_q != ADDR_NULL) begin
            nwe1 = 1'b1;
            nwa1 = prev_q;
            nwd1 = cur_next;
        end
    end

    // NOTE: node payload/pointer memories carry no reset; the valid bitmap
    // alone decides which entries are meaningful, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (dwe)  data_mem[ix(dwa)]  <= dwd;
        if (nwe0) next_mem[ix(nwa0)] <= nwd0;
        if (nwe1) next_mem[ix(nwa1)] <= nwd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register sees the pre-edge values of the others within the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q           <= OP_READ;
            list_q         <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            cur_q          <= ADDR_NULL;
            prev_q         <= ADDR_NULL;
            valid_q        <= '0;
            data_out       <= '0;
            addr_out       <= ADDR_NULL;
            next_node_addr <= ADDR_NULL;
            fault          <= 1'b0;
            for (int i = 0; i < NUM_LISTS; i++) begin
                head_q[i] <= ADDR_NULL;
                tail_q[i] <= ADDR_NULL;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_start) begin
                        op_q   <= op_e'(op);
                        list_q <= list_in;
                        addr_q <= addr_in;
                        data_q <= data_in;
                        cur_q  <= (32'(list_in) < NUM_LISTS) ? head_q[list_in] : ADDR_NULL;
                        prev_q <= ADDR_NULL;
                    end
                end
                ST_EXEC: begin
                    fault <= exec_fault;
                    if (!exec_fault) begin
                        case (op_q)
                            OP_READ: begin
                                data_out       <= data_mem[ix(addr_q)];
                                addr_out       <= addr_q;
                                next_node_addr <= next_mem[ix(addr_q)];
                            end
                            OP_INSERT_HEAD: begin
                                valid_q[ix(free_addr)] <= 1'b1;
                                head_q[lsel]           <= free_addr;
                                if (lhead == ADDR_NULL) tail_q[lsel] <= free_addr;
                                data_out               <= data_q;
                                addr_out               <= free_addr;
                                next_node_addr         <= lhead;
                            end
                            OP_INSERT_TAIL: begin
                                valid_q[ix(free_addr)] <= 1'b1;
                                tail_q[lsel]           <= free_addr;
                                if (ltail == ADDR_NULL) head_q[lsel] <= free_addr;
                                data_out               <= data_q;
                                addr_out               <= free_addr;
                                next_node_addr         <= ADDR_NULL;
                            end
                            OP_INSERT_AFTER: begin
                                valid_q[ix(free_addr)] <= 1'b1;
                                if (ltail == addr_q) tail_q[lsel] <= free_addr;
                                data_out               <= data_q;
                                addr_out               <= free_addr;
                                next_node_addr         <= next_mem[ix(addr_q)];
                            end
                            OP_POP_HEAD: begin
                                valid_q[ix(lhead)] <= 1'b0;
                                head_q[lsel]       <= next_mem[ix(lhead)];
                                if (ltail == lhead) tail_q[lsel] <= ADDR_NULL;
                                data_out           <= data_mem[ix(lhead)];
                                addr_out           <= lhead;
                                next_node_addr     <= next_mem[ix(lhead)];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_TRAVERSE: begin
                    if (trav_end) begin
                        fault <= 1'b1;
                    end else if (cur_match) begin
                        fault              <= 1'b0;
                        valid_q[ix(cur_q)] <= 1'b0;
                        if (prev_q == ADDR_NULL) head_q[lsel] <= cur_next;
                        if (ltail == cur_q)      tail_q[lsel] <= prev_q;
                        data_out           <= data_mem[ix(cur_q)];
                        addr_out           <= cur_q;
                        next_node_addr     <= cur_next;
                    end else begin
                        prev_q <= cur_q;
                        cur_q  <= cur_next;
                    end
                end
                ST_DONE: fault <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
